// File: rtl/vid_mem_arbiter_pkg.sv
// Shared types and address map for the video memory arbiter.
// Optional build macro used by the top: ARB_STRICT_MODE_EN.
package vid_mem_arbiter_pkg;

    typedef enum logic [1:0] {MODE_0, MODE_1, MODE_2, MODE_3} ppu_mode_t;

    // Registered steering for cpu_dout, decided in the strobe cycle.
    typedef enum logic [1:0] {SEL_FF, SEL_VRAM, SEL_OAM, SEL_REG} rd_sel_t;

    typedef logic [2:0] dma_state_t;
    localparam dma_state_t DMA_IDLE  = 3'd0;
    localparam dma_state_t DMA_START = 3'd1;
    localparam dma_state_t DMA_RD    = 3'd2;
    localparam dma_state_t DMA_WAIT  = 3'd3;
    localparam dma_state_t DMA_WR    = 3'd4;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_TOP  = 16'h9FFF;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] OAM_TOP   = 16'hFE9F;
    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam logic [15:0] HRAM_TOP  = 16'hFFFE;
    localparam logic [15:0] REG_DMA   = 16'hFF46;

    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/vid_mem_arbiter_if.sv
// CPU-side bus into the video memory arbiter; cpu_dout/cpu_blk describe the
// strobe of the previous clock.
interface vid_mem_arbiter_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic        cpu_blk;

    modport master (output cpu_a, cpu_din, cpu_rd, cpu_wr, input cpu_dout, cpu_blk);
    modport slave  (input cpu_a, cpu_din, cpu_rd, cpu_wr, output cpu_dout, cpu_blk);
endinterface

// File: rtl/vid_mem_arbiter_oam_dma_engine.sv
// OAM DMA sequencer: FF46 source latch, start delay, then one byte per
// DMA_BYTE_CYCLES clocks (read system bus, write OAM).
module oam_dma_engine
    import vid_mem_arbiter_pkg::*;
#(
    parameter int DMA_LEN         = 160,
    parameter int DMA_BYTE_CYCLES = 4,
    parameter int DMA_START_DELAY = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        reg_wr,
    input  logic [7:0]  reg_din,
    input  logic [7:0]  sys_dout,
    output logic [7:0]  src_hi,
    output logic        dma_active,
    output logic [15:0] sys_a,
    output logic        sys_rd,
    output logic [15:0] oam_a,
    output logic [7:0]  oam_din,
    output logic        oam_wr
);

    localparam logic [7:0] START_LAST = 8'(DMA_START_DELAY - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(DMA_BYTE_CYCLES - 3);
    localparam logic [7:0] IDX_LAST   = 8'(DMA_LEN - 1);

    dma_state_t state;
    logic [7:0] cnt;
    logic [7:0] idx;
    logic [7:0] data_q;
    logic [7:0] src_eff;
    logic       rd_d;

    // Echo RAM (E000-FDFF) mirrors C000-DDFF.
    assign src_eff    = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
    assign dma_active = (state != DMA_IDLE);
    assign sys_rd     = (state == DMA_RD);
    assign sys_a      = sys_rd ? {src_eff, idx} : 16'h0000;
    assign oam_wr     = (state == DMA_WR);
    assign oam_a      = oam_wr ? (OAM_BASE + {8'h00, idx}) : 16'h0000;
    // With no wait cycles the byte is still on sys_dout during the write.
    assign oam_din    = oam_wr ? (rd_d ? sys_dout : data_q) : 8'h00;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state  <= DMA_IDLE;
            cnt    <= 8'h00;
            idx    <= 8'h00;
            src_hi <= 8'h00;
            data_q <= 8'h00;
            rd_d   <= 1'b0;
        end else begin
            rd_d <= sys_rd;
            if (rd_d) data_q <= sys_dout;
            if (reg_wr) begin
                src_hi <= reg_din;
                state  <= DMA_START;
                cnt    <= 8'h00;
                idx    <= 8'h00;
            end else begin
                case (state)
                    DMA_START: begin
                        if (cnt == START_LAST) begin
                            state <= DMA_RD;
                            cnt   <= 8'h00;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    DMA_RD: begin
                        cnt   <= 8'h00;
                        state <= (DMA_BYTE_CYCLES > 2) ? DMA_WAIT : DMA_WR;
                    end
                    DMA_WAIT: begin
                        if (cnt == WAIT_LAST) state <= DMA_WR;
                        else                  cnt   <= cnt + 8'd1;
                    end
                    DMA_WR: begin
                        if (idx == IDX_LAST) begin
                            state <= DMA_IDLE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= DMA_RD;
                        end
                    end
                    default: state <= DMA_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/vid_mem_arbiter.sv
// VRAM/OAM arbiter between CPU, PPU fetchers and OAM DMA; owns FF46.
// Build macro ARB_STRICT_MODE_EN enables PPU-mode based CPU blocking.
module vid_mem_arbiter
    import vid_mem_arbiter_pkg::*;
#(
    parameter int DMA_LEN         = 160,
    parameter int DMA_BYTE_CYCLES = 4,
    parameter int DMA_START_DELAY = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        lcd_en,
    input  ppu_mode_t   ppu_mode,
    input  logic [15:0] ppu_vram_a,
    input  logic        ppu_vram_rd,
    output logic [7:0]  ppu_vram_dout,
    input  logic [15:0] ppu_oam_a,
    input  logic        ppu_oam_rd,
    output logic [7:0]  ppu_oam_dout,
    vid_mem_arbiter_if.slave cpu,
    output logic [15:0] sys_a,
    output logic        sys_rd,
    input  logic [7:0]  sys_dout,
    output logic [15:0] vram_a,
    output logic [7:0]  vram_din,
    output logic        vram_rd,
    output logic        vram_wr,
    input  logic [7:0]  vram_dout,
    output logic [15:0] oam_a,
    output logic [7:0]  oam_din,
    output logic        oam_rd,
    output logic        oam_wr,
    input  logic [7:0]  oam_dout,
    output logic        dma_active
);

    ppu_mode_t   eff_mode;
    logic        cpu_acc, in_vram, in_oam, in_hram, in_reg;
    logic        dma_blk, vram_mode_blk, oam_mode_blk;
    logic        cpu_vram_go, cpu_oam_go, blk_now;
    logic        ppu_vram_req, ppu_oam_req, ppu_vram_gnt, ppu_oam_gnt;
    logic        reg_wr;
    logic [7:0]  src_hi;
    logic [15:0] dma_oam_a;
    logic [7:0]  dma_oam_din;
    logic        dma_oam_wr;
    rd_sel_t     rsel_q;
    logic        blk_q, ppu_vsel_q, ppu_osel_q;

    assign eff_mode = lcd_en ? ppu_mode : MODE_0;
    assign cpu_acc  = cpu.cpu_rd | cpu.cpu_wr;
    assign in_vram  = in_range(cpu.cpu_a, VRAM_BASE, VRAM_TOP);
    assign in_oam   = in_range(cpu.cpu_a, OAM_BASE, OAM_TOP);
    assign in_hram  = in_range(cpu.cpu_a, HRAM_BASE, HRAM_TOP);
    assign in_reg   = (cpu.cpu_a == REG_DMA);

    // FF46 stays reachable during DMA so software can restart a transfer.
    assign dma_blk = dma_active && !in_hram && !in_reg;

`ifdef ARB_STRICT_MODE_EN
    assign vram_mode_blk = (eff_mode == MODE_3);
    assign oam_mode_blk  = (eff_mode == MODE_2) || (eff_mode == MODE_3);
`else
    assign vram_mode_blk = 1'b0;
    assign oam_mode_blk  = 1'b0;
`endif

    assign ppu_vram_req = ppu_vram_rd && (eff_mode == MODE_3);
    assign ppu_oam_req  = ppu_oam_rd && ((eff_mode == MODE_2) || (eff_mode == MODE_3));
    assign cpu_vram_go  = cpu_acc && in_vram && !dma_blk && !vram_mode_blk;
    assign cpu_oam_go   = cpu_acc && in_oam && !dma_blk && !oam_mode_blk;
    assign blk_now      = cpu_acc && (dma_blk || (in_vram && vram_mode_blk)
                                              || (in_oam && oam_mode_blk));
    assign reg_wr       = cpu.cpu_wr && in_reg;

    oam_dma_engine #(
        .DMA_LEN         (DMA_LEN),
        .DMA_BYTE_CYCLES (DMA_BYTE_CYCLES),
        .DMA_START_DELAY (DMA_START_DELAY)
    ) u_dma (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .reg_wr     (reg_wr),
        .reg_din    (cpu.cpu_din),
        .sys_dout   (sys_dout),
        .src_hi     (src_hi),
        .dma_active (dma_active),
        .sys_a      (sys_a),
        .sys_rd     (sys_rd),
        .oam_a      (dma_oam_a),
        .oam_din    (dma_oam_din),
        .oam_wr     (dma_oam_wr)
    );

    // CPU ahead of PPU here: in strict builds the CPU is already blocked in mode 3.
    always_comb begin
        vram_a       = 16'h0000;
        vram_din     = 8'h00;
        vram_rd      = 1'b0;
        vram_wr      = 1'b0;
        ppu_vram_gnt = 1'b0;
        if (cpu_vram_go) begin
            vram_a   = cpu.cpu_a;
            vram_din = cpu.cpu_din;
            vram_rd  = cpu.cpu_rd;
            vram_wr  = cpu.cpu_wr;
        end else if (ppu_vram_req) begin
            vram_a       = ppu_vram_a;
            vram_rd      = 1'b1;
            ppu_vram_gnt = 1'b1;
        end
    end

    always_comb begin
        oam_a       = 16'h0000;
        oam_din     = 8'h00;
        oam_rd      = 1'b0;
        oam_wr      = 1'b0;
        ppu_oam_gnt = 1'b0;
        if (dma_oam_wr) begin
            oam_a   = dma_oam_a;
            oam_din = dma_oam_din;
            oam_wr  = 1'b1;
        end else if (cpu_oam_go) begin
            oam_a   = cpu.cpu_a;
            oam_din = cpu.cpu_din;
            oam_rd  = cpu.cpu_rd;
            oam_wr  = cpu.cpu_wr;
        end else if (ppu_oam_req) begin
            oam_a       = ppu_oam_a;
            oam_rd      = 1'b1;
            ppu_oam_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rsel_q     <= SEL_FF;
            blk_q      <= 1'b0;
            ppu_vsel_q <= 1'b0;
            ppu_osel_q <= 1'b0;
        end else begin
            if (cpu.cpu_rd) begin
                if (cpu_vram_go)     rsel_q <= SEL_VRAM;
                else if (cpu_oam_go) rsel_q <= SEL_OAM;
                else if (in_reg)     rsel_q <= SEL_REG;
                else                 rsel_q <= SEL_FF;
            end
            blk_q      <= blk_now;
            ppu_vsel_q <= ppu_vram_gnt;
            ppu_osel_q <= ppu_oam_gnt;
        end
    end

    always_comb begin
        case (rsel_q)
            SEL_VRAM: cpu.cpu_dout = vram_dout;
            SEL_OAM:  cpu.cpu_dout = oam_dout;
            SEL_REG:  cpu.cpu_dout = src_hi;
            default:  cpu.cpu_dout = 8'hFF;
        endcase
    end

    assign cpu.cpu_blk    = blk_q;
    assign ppu_vram_dout  = ppu_vsel_q ? vram_dout : 8'hFF;
    assign ppu_oam_dout   = ppu_osel_q ? oam_dout : 8'hFF;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Directed bench for vid_mem_arbiter with BRAM and system-bus models;
// expectations follow ARB_STRICT_MODE_EN when it is defined.
module tb_vid_mem_arbiter;
    import vid_mem_arbiter_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        lcd_en;
    ppu_mode_t   ppu_mode;
    logic [15:0] ppu_vram_a, ppu_oam_a;
    logic        ppu_vram_rd, ppu_oam_rd;
    logic [7:0]  ppu_vram_dout, ppu_oam_dout;
    logic [15:0] sys_a, vram_a, oam_a;
    logic        sys_rd, vram_rd, vram_wr, oam_rd, oam_wr, dma_active;
    logic [7:0]  sys_dout, vram_din, vram_dout, oam_din, oam_dout;
    logic [7:0]  vram_mem [0:8191];
    logic [7:0]  oam_mem  [0:159];
    int          checks = 0;
    int          failures = 0;

`ifdef ARB_STRICT_MODE_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    vid_mem_arbiter_if cif();

    vid_mem_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .lcd_en(lcd_en), .ppu_mode(ppu_mode),
        .ppu_vram_a(ppu_vram_a), .ppu_vram_rd(ppu_vram_rd), .ppu_vram_dout(ppu_vram_dout),
        .ppu_oam_a(ppu_oam_a), .ppu_oam_rd(ppu_oam_rd), .ppu_oam_dout(ppu_oam_dout),
        .cpu(cif), .sys_a(sys_a), .sys_rd(sys_rd), .sys_dout(sys_dout),
        .vram_a(vram_a), .vram_din(vram_din), .vram_rd(vram_rd), .vram_wr(vram_wr),
        .vram_dout(vram_dout), .oam_a(oam_a), .oam_din(oam_din), .oam_rd(oam_rd),
        .oam_wr(oam_wr), .oam_dout(oam_dout), .dma_active(dma_active)
    );

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk_in) begin
        if (vram_wr) vram_mem[vram_a[12:0]] <= vram_din;
        if (vram_rd) vram_dout <= vram_mem[vram_a[12:0]];
        if (oam_wr && oam_a[7:0] < 8'd160) oam_mem[oam_a[7:0]] <= oam_din;
        if (oam_rd) oam_dout <= (oam_a[7:0] < 8'd160) ? oam_mem[oam_a[7:0]] : 8'hFF;
        if (sys_rd) sys_dout <= src_byte(sys_a);
    end

    task automatic cpu_rd_cyc(input logic [15:0] a);
        cif.cpu_a = a; cif.cpu_rd = 1'b1;
        @(negedge clk_in);
        cif.cpu_rd = 1'b0;
    endtask

    task automatic cpu_wr_cyc(input logic [15:0] a, input logic [7:0] d);
        cif.cpu_a = a; cif.cpu_din = d; cif.cpu_wr = 1'b1;
        @(negedge clk_in);
        cif.cpu_wr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (dma_active === 1'b1 && n < 1000) begin n++; @(negedge clk_in); end
        checks++;
        if (dma_active !== 1'b0) begin
            failures++; $display("FAIL %s_done: dma_active=%b required 0 within 1000 clks", tag, dma_active);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL rst_active: got %b req 0", dma_active); end
        checks++; if (cif.cpu_dout !== 8'hFF) begin failures++; $display("FAIL rst_dout: got %h req ff", cif.cpu_dout); end
        checks++; if ({sys_rd, oam_wr, vram_rd, vram_wr} !== 4'b0) begin failures++; $display("FAIL rst_strobes: got %b req 0000", {sys_rd, oam_wr, vram_rd, vram_wr}); end
        checks++; if ({sys_a, oam_a, vram_a} !== 48'h0) begin failures++; $display("FAIL rst_addr: got %h req 0", {sys_a, oam_a, vram_a}); end
        @(negedge clk_in); rst_n_in = 1'b1; @(negedge clk_in);
        cpu_rd_cyc(REG_DMA);
        checks++; if (cif.cpu_dout !== 8'h00) begin failures++; $display("FAIL rst_ff46: got %h req 00", cif.cpu_dout); end
    endtask

    task automatic test_dma_full();
        int n = 0, first_rd = 0, nrd = 0, nwr = 0, bad = 0, obad = 0;
        cpu_wr_cyc(REG_DMA, 8'hC1);
        while (dma_active === 1'b1 && n < 2000) begin
            n++;
            if (sys_rd) begin
                if (nrd == 0) first_rd = n;
                if (sys_a !== {8'hC1, 8'(nrd)}) bad++;
                nrd++;
            end
            if (oam_wr) begin
                if (oam_a !== 16'hFE00 + 16'(nwr)) bad++;
                nwr++;
            end
            @(negedge clk_in);
        end
        for (int i = 0; i < 160; i++) if (oam_mem[i] !== src_byte({8'hC1, 8'(i)})) obad++;
        checks++; if (n != 644) begin failures++; $display("FAIL dma_len: active %0d clks req 644", n); end
        checks++; if (first_rd != 5) begin failures++; $display("FAIL dma_first_rd: clk %0d req 5", first_rd); end
        checks++; if (nrd != 160 || nwr != 160) begin failures++; $display("FAIL dma_count: rd %0d wr %0d req 160/160", nrd, nwr); end
        checks++; if (bad != 0) begin failures++; $display("FAIL dma_addr: %0d bad addresses req 0", bad); end
        checks++; if (obad != 0) begin failures++; $display("FAIL dma_oam: %0d bad bytes req 0", obad); end
    endtask

    task automatic test_vram_mode();
        lcd_en = 1'b1; ppu_mode = MODE_0;
        cpu_wr_cyc(16'h8010, 8'hA7);
        cpu_wr_cyc(16'h8020, 8'h3C);
        ppu_mode = MODE_3; ppu_vram_a = 16'h8020; ppu_vram_rd = 1'b1;
        cif.cpu_a = 16'h8010; cif.cpu_rd = 1'b1;
        #1;
        checks++; if (vram_a !== (STRICT ? 16'h8020 : 16'h8010)) begin failures++; $display("FAIL m3_vram_a: got %h req %h", vram_a, STRICT ? 16'h8020 : 16'h8010); end
        @(negedge clk_in); cif.cpu_rd = 1'b0; ppu_vram_rd = 1'b0;
        checks++; if (cif.cpu_dout !== (STRICT ? 8'hFF : 8'hA7)) begin failures++; $display("FAIL m3_cpu_dout: got %h req %h", cif.cpu_dout, STRICT ? 8'hFF : 8'hA7); end
        checks++; if (ppu_vram_dout !== (STRICT ? 8'h3C : 8'hFF)) begin failures++; $display("FAIL m3_ppu_dout: got %h req %h", ppu_vram_dout, STRICT ? 8'h3C : 8'hFF); end
        checks++; if (cif.cpu_blk !== STRICT) begin failures++; $display("FAIL m3_blk: got %b req %b", cif.cpu_blk, STRICT); end
        ppu_mode = MODE_0;
        cpu_rd_cyc(16'h8010);
        checks++; if (cif.cpu_dout !== 8'hA7) begin failures++; $display("FAIL m0_vram_rd: got %h req a7", cif.cpu_dout); end
        lcd_en = 1'b0; ppu_mode = MODE_3;
        cpu_rd_cyc(16'h8020);
        checks++; if (cif.cpu_dout !== 8'h3C) begin failures++; $display("FAIL lcdoff_vram_rd: got %h req 3c", cif.cpu_dout); end
        lcd_en = 1'b1; ppu_mode = MODE_0;
    endtask

    task automatic test_oam_mode();
        ppu_mode = MODE_2;
        cif.cpu_a = 16'hFE04; cif.cpu_din = 8'h55; cif.cpu_wr = 1'b1;
        #1;
        checks++; if (oam_wr !== !STRICT) begin failures++; $display("FAIL m2_oam_wr: got %b req %b", oam_wr, !STRICT); end
        @(negedge clk_in); cif.cpu_wr = 1'b0;
        checks++; if (oam_mem[4] !== (STRICT ? src_byte(16'hC104) : 8'h55)) begin failures++; $display("FAIL m2_oam_mem: got %h req %h", oam_mem[4], STRICT ? src_byte(16'hC104) : 8'h55); end
        ppu_mode = MODE_1;
        cpu_wr_cyc(16'hFE04, 8'h55);
        checks++; if (oam_mem[4] !== 8'h55) begin failures++; $display("FAIL m1_oam_mem: got %h req 55", oam_mem[4]); end
        cpu_rd_cyc(16'hFE04);
        checks++; if (cif.cpu_dout !== 8'h55) begin failures++; $display("FAIL m1_oam_rd: got %h req 55", cif.cpu_dout); end
        ppu_mode = MODE_0;
    endtask

    task automatic test_dma_restart();
        int n = 0, pre_wr = 0;
        cpu_wr_cyc(REG_DMA, 8'hC1);
        while (!(sys_rd === 1'b1 && sys_a[7:0] == 8'd50) && n < 1000) begin n++; @(negedge clk_in); end
        checks++; if (n >= 1000) begin failures++; $display("FAIL rs_reach50: no read of idx 50 in 1000 clks"); end
        cpu_wr_cyc(REG_DMA, 8'hD0);
        n = 0;
        while (sys_rd !== 1'b1 && n < 100) begin if (oam_wr) pre_wr++; n++; @(negedge clk_in); end
        checks++; if (sys_a !== 16'hD000) begin failures++; $display("FAIL rs_src: got %h req d000", sys_a); end
        checks++; if (pre_wr != 0) begin failures++; $display("FAIL rs_stale_wr: %0d writes req 0", pre_wr); end
        n = 0;
        while (oam_wr !== 1'b1 && n < 100) begin n++; @(negedge clk_in); end
        checks++; if ({oam_a, oam_din} !== {16'hFE00, src_byte(16'hD000)}) begin failures++; $display("FAIL rs_first_wr: got %h req %h", {oam_a, oam_din}, {16'hFE00, src_byte(16'hD000)}); end
        wait_done("rs");
        checks++; if (oam_mem[50] !== src_byte(16'hD032)) begin failures++; $display("FAIL rs_oam50: got %h req %h", oam_mem[50], src_byte(16'hD032)); end
    endtask

    task automatic test_dma_block();
        int n = 0;
        logic [7:0] idx;
        cpu_wr_cyc(REG_DMA, 8'hC1);
        cpu_rd_cyc(16'hFF90);
        checks++; if (cif.cpu_blk !== 1'b0) begin failures++; $display("FAIL blk_hram: blk %b req 0", cif.cpu_blk); end
        cpu_rd_cyc(16'hC000);
        checks++; if ({cif.cpu_blk, cif.cpu_dout} !== 9'h1FF) begin failures++; $display("FAIL blk_c000: got %h req 1ff", {cif.cpu_blk, cif.cpu_dout}); end
        cif.cpu_a = 16'h8010; cif.cpu_rd = 1'b1;
        #1;
        checks++; if (vram_rd !== 1'b0) begin failures++; $display("FAIL blk_vram_rd: got %b req 0", vram_rd); end
        @(negedge clk_in); cif.cpu_rd = 1'b0;
        checks++; if (cif.cpu_dout !== 8'hFF) begin failures++; $display("FAIL blk_vram_dout: got %h req ff", cif.cpu_dout); end
        while (oam_wr !== 1'b1 && n < 100) begin n++; @(negedge clk_in); end
        idx = oam_a[7:0];
        cpu_wr_cyc(REG_DMA, 8'hE3);
        checks++; if (oam_mem[idx] !== src_byte({8'hC1, idx})) begin failures++; $display("FAIL blk_wr_completes: got %h req %h", oam_mem[idx], src_byte({8'hC1, idx})); end
        cpu_rd_cyc(REG_DMA);
        checks++; if (cif.cpu_dout !== 8'hE3) begin failures++; $display("FAIL blk_ff46_rd: got %h req e3", cif.cpu_dout); end
        n = 0;
        while (sys_rd !== 1'b1 && n < 100) begin n++; @(negedge clk_in); end
        checks++; if (sys_a !== 16'hC300) begin failures++; $display("FAIL blk_echo_src: got %h req c300", sys_a); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        while (!(oam_wr === 1'b1 && oam_a == 16'hFE9F) && n < 1000) begin n++; @(negedge clk_in); end
        checks++; if (n >= 1000) begin failures++; $display("FAIL b2b_last_wr: no write to fe9f in 1000 clks"); end
        cpu_wr_cyc(REG_DMA, 8'h80);
        checks++; if (dma_active !== 1'b1) begin failures++; $display("FAIL b2b_active: got %b req 1", dma_active); end
        checks++; if (oam_mem[159] !== src_byte(16'hC39F)) begin failures++; $display("FAIL b2b_oam159: got %h req %h", oam_mem[159], src_byte(16'hC39F)); end
        n = 0;
        while (sys_rd !== 1'b1 && n < 100) begin n++; @(negedge clk_in); end
        checks++; if (sys_a !== 16'h8000) begin failures++; $display("FAIL b2b_src: got %h req 8000", sys_a); end
        wait_done("b2b");
    endtask

    task automatic test_async_reset();
        int n = 0, nrd = 0;
        cpu_wr_cyc(REG_DMA, 8'hC1);
        while (!(sys_rd === 1'b1 && sys_a[7:0] == 8'd20) && n < 1000) begin n++; @(negedge clk_in); end
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if ({dma_active, sys_rd, oam_wr} !== 3'b000) begin failures++; $display("FAIL ar_strobes: got %b req 000", {dma_active, sys_rd, oam_wr}); end
        checks++; if (sys_a !== 16'h0000) begin failures++; $display("FAIL ar_sys_a: got %h req 0000", sys_a); end
        @(negedge clk_in); rst_n_in = 1'b1;
        for (int i = 0; i < 10; i++) begin if (sys_rd) nrd++; @(negedge clk_in); end
        checks++; if (nrd != 0 || dma_active !== 1'b0) begin failures++; $display("FAIL ar_idle: reads %0d active %b req 0/0", nrd, dma_active); end
        cpu_rd_cyc(REG_DMA);
        checks++; if (cif.cpu_dout !== 8'h00) begin failures++; $display("FAIL ar_ff46: got %h req 00", cif.cpu_dout); end
    endtask

    initial begin
        lcd_en = 1'b1; ppu_mode = MODE_0;
        ppu_vram_a = 16'h0; ppu_vram_rd = 1'b0; ppu_oam_a = 16'h0; ppu_oam_rd = 1'b0;
        cif.cpu_a = 16'h0; cif.cpu_din = 8'h0; cif.cpu_rd = 1'b0; cif.cpu_wr = 1'b0;
        test_reset();
        test_dma_full();
        test_vram_mode();
        test_oam_mode();
        test_dma_restart();
        test_dma_block();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
